game_round_sequencer: RTL

//  Top-level round FSM for hole-in-the-wall. Sequences the wall datapath: resets and launches the wall.

---
 rtl/game_pkg.sv | 21 ++
 rtl/game_round_sequencer_if.sv | 25 ++
 rtl/collision_accumulator.sv | 54 +++++
 rtl/evt_counter.sv | 26 ++
 rtl/game_round_sequencer.sv | 187 ++++++++++++++++++
 5 files changed

// File: rtl/game_pkg.sv
// Shared round-state encoding for the round sequencer and the renderer.
// Also holds small helpers used by the sequencer datapath.
package game_pkg;

  localparam int STATE_W = 3;
  localparam int COUNT_W = 16;

  typedef enum logic [STATE_W-1:0] {
    IDLE      = 3'd0,
    COUNTDOWN = 3'd1,
    PLAY      = 3'd2,
    EVAL      = 3'd3,
    RESULT    = 3'd4,
    GAME_OVER = 3'd5
  } game_state_t;

  function automatic logic [7:0] sat_inc8(input logic [7:0] v);
    return (v == 8'hFF) ? v : v + 8'd1;
  endfunction

endpackage

// File: rtl/game_round_sequencer_if.sv
// Pixel stream seen by the round sequencer: raster position,
// classifier flags and the two depths being compared.
interface game_round_sequencer_if;

  logic [10:0] hcount;
  logic [9:0]  vcount;
  logic        data_valid;
  logic        is_person;
  logic        is_wall;
  logic [7:0]  player_depth;
  logic [7:0]  wall_depth;

  modport master (
    output hcount, vcount, data_valid,
    output is_person, is_wall,
    output player_depth, wall_depth
  );

  modport slave (
    input hcount, vcount, data_valid,
    input is_person, is_wall,
    input player_depth, wall_depth
  );

endinterface

// File: rtl/collision_accumulator.sv
// Counts person-on-wall pixels whose depth is close to the wall.
// The 16-bit count saturates instead of wrapping.
module collision_accumulator #(
  parameter int DELTA = 10
) (
  input  logic        clk_in,
  input  logic        rst_in,
  input  logic        clear_in,
  input  logic        enable_in,
  input  logic        valid_in,
  input  logic        is_person_in,
  input  logic        is_wall_in,
  input  logic [7:0]  player_depth_in,
  input  logic [7:0]  wall_depth_in,
  output logic [15:0] count_out
);

  logic [8:0]  diff;
  logic        hit;
  logic [15:0] count_q, count_d;

  // absolute depth difference and pixel qualification
  always_comb begin
    if (player_depth_in >= wall_depth_in) begin
      diff = {1'b0, player_depth_in} - {1'b0, wall_depth_in};
    end else begin
      diff = {1'b0, wall_depth_in} - {1'b0, player_depth_in};
    end
    hit = valid_in && is_person_in && is_wall_in &&
          (diff <= 9'(DELTA));
  end

  // next count: clear, else saturating increment on a hit
  always_comb begin
    count_d = count_q;
    if (clear_in) begin
      count_d = '0;
    end else if (enable_in && hit && (count_q != 16'hFFFF)) begin
      count_d = count_q + 16'd1;
    end
  end

  // count register
  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign count_out = count_q;

endmodule

// File: rtl/evt_counter.sv
// Counts single-cycle events; clear has priority and zeroes the count.
// Wraps naturally at 2**W.
module evt_counter #(
  parameter int W = 8
) (
  input  logic         clk_in,
  input  logic         rst_in,
  input  logic         clr_in,
  input  logic         evt_in,
  output logic [W-1:0] count_out
);

  logic [W-1:0] count_q;

  // count register: clear wins over increment
  always_ff @(posedge clk_in) begin
    if (rst_in || clr_in) begin
      count_q <= '0;
    end else if (evt_in) begin
      count_q <= count_q + W'(1);
    end
  end

  assign count_out = count_q;

endmodule

// File: rtl/game_round_sequencer.sv
// Round FSM for hole-in-the-wall: countdown, play, one-frame
// collision evaluation, scoring, lives and wall speed.
module game_round_sequencer
  import game_pkg::*;
#(
  parameter int SCREEN_WIDTH             = 1280,
  parameter int SCREEN_HEIGHT            = 720,
  parameter int GOAL_DEPTH               = 60,
  parameter int GOAL_DEPTH_DELTA         = 10,
  parameter int COUNTDOWN_FRAMES         = 90,
  parameter int COLLISION_THRESHOLD      = 64,
  parameter int START_LIVES              = 3,
  parameter int MAX_FRAMES_PER_WALL_TICK = 15,
  parameter int MIN_FRAMES_PER_WALL_TICK = 3,
  parameter int SPEEDUP_ROUNDS           = 2,
  localparam int TW = $clog2(MAX_FRAMES_PER_WALL_TICK + 1)
) (
  input  logic                   clk_in,
  input  logic                   rst_in,
  input  logic                   start_in,
  game_round_sequencer_if.slave  pix_if,
  output logic                   wall_depth_rst_out,
  output logic [TW-1:0]          wall_tick_frequency_out,
  output logic                   wall_idx_out,
  output game_state_t            game_state,
  output logic [7:0]             round_out,
  output logic [7:0]             score_out,
  output logic [1:0]             lives_out,
  output logic [15:0]            collision_count_out,
  output logic                   round_pass_out,
  output logic                   round_fail_out
);

  localparam int CD_W  = $clog2(COUNTDOWN_FRAMES + 1);
  localparam int SPD_W =
    (SPEEDUP_ROUNDS > 1) ? $clog2(SPEEDUP_ROUNDS) : 1;

  game_state_t      state_q, state_d;
  logic [7:0]       round_q, round_d;
  logic [7:0]       score_q, score_d;
  logic [1:0]       lives_q, lives_d;
  logic [TW-1:0]    freq_q, freq_d;
  logic [SPD_W-1:0] spd_q, spd_d;
  logic             idx_q, idx_d;
  logic [15:0]      cc_q, cc_d;
  logic             pass_q, pass_d;
  logic             fail_q, fail_d;
  logic             wrst_q, wrst_d;

  logic             new_frame;
  logic [CD_W-1:0]  cd_count;
  logic             cd_done;
  logic [15:0]      acc_count;
  logic             is_pass;

  assign new_frame = pix_if.data_valid &&
    (pix_if.hcount == 11'(SCREEN_WIDTH - 1)) &&
    (pix_if.vcount == 10'(SCREEN_HEIGHT - 1));

  evt_counter #(.W(CD_W)) u_countdown (
    .clk_in    (clk_in),
    .rst_in    (rst_in),
    .clr_in    (state_q != COUNTDOWN),
    .evt_in    (new_frame),
    .count_out (cd_count)
  );

  assign cd_done = new_frame &&
    (cd_count == CD_W'(COUNTDOWN_FRAMES - 1));

  collision_accumulator #(.DELTA(GOAL_DEPTH_DELTA)) u_acc (
    .clk_in          (clk_in),
    .rst_in          (rst_in),
    .clear_in        (state_q != EVAL),
    .enable_in       (state_q == EVAL),
    .valid_in        (pix_if.data_valid),
    .is_person_in    (pix_if.is_person),
    .is_wall_in      (pix_if.is_wall),
    .player_depth_in (pix_if.player_depth),
    .wall_depth_in   (pix_if.wall_depth),
    .count_out       (acc_count)
  );

  assign is_pass = (acc_count <= 16'(COLLISION_THRESHOLD));

  // next state plus score, lives and speed bookkeeping
  always_comb begin
    state_d = state_q;
    round_d = round_q;
    score_d = score_q;
    lives_d = lives_q;
    freq_d  = freq_q;
    spd_d   = spd_q;
    idx_d   = idx_q;
    cc_d    = cc_q;
    pass_d  = 1'b0;
    fail_d  = 1'b0;
    unique case (state_q)
      IDLE, GAME_OVER: begin
        if (start_in) begin
          state_d = COUNTDOWN;
          round_d = '0;
          score_d = '0;
          lives_d = 2'(START_LIVES);
          freq_d  = TW'(MAX_FRAMES_PER_WALL_TICK);
          spd_d   = '0;
        end
      end
      COUNTDOWN: begin
        if (cd_done) state_d = PLAY;
      end
      PLAY: begin
        if (new_frame &&
            (pix_if.wall_depth >= 8'(GOAL_DEPTH))) begin
          state_d = EVAL;
        end
      end
      EVAL: begin
        if (new_frame) state_d = RESULT;
      end
      RESULT: begin
        round_d = sat_inc8(round_q);
        cc_d    = acc_count;
        idx_d   = ~idx_q;
        if (is_pass) begin
          score_d = sat_inc8(score_q);
          pass_d  = 1'b1;
          if (spd_q == SPD_W'(SPEEDUP_ROUNDS - 1)) begin
            spd_d = '0;
            if (freq_q > TW'(MIN_FRAMES_PER_WALL_TICK)) begin
              freq_d = freq_q - TW'(1);
            end
          end else begin
            spd_d = spd_q + SPD_W'(1);
          end
        end else begin
          fail_d = 1'b1;
          if (lives_q != 2'd0) lives_d = lives_q - 2'd1;
        end
        state_d = (lives_d == 2'd0) ? GAME_OVER : COUNTDOWN;
      end
      default: state_d = IDLE;
    endcase
    wrst_d = !((state_d == PLAY) || (state_d == EVAL));
  end

  // state and output registers
  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      state_q <= IDLE;
      round_q <= '0;
      score_q <= '0;
      lives_q <= 2'(START_LIVES);
      freq_q  <= TW'(MAX_FRAMES_PER_WALL_TICK);
      spd_q   <= '0;
      idx_q   <= 1'b0;
      cc_q    <= '0;
      pass_q  <= 1'b0;
      fail_q  <= 1'b0;
      wrst_q  <= 1'b1;
    end else begin
      state_q <= state_d;
      round_q <= round_d;
      score_q <= score_d;
      lives_q <= lives_d;
      freq_q  <= freq_d;
      spd_q   <= spd_d;
      idx_q   <= idx_d;
      cc_q    <= cc_d;
      pass_q  <= pass_d;
      fail_q  <= fail_d;
      wrst_q  <= wrst_d;
    end
  end

  assign game_state              = state_q;
  assign round_out               = round_q;
  assign score_out               = score_q;
  assign lives_out               = lives_q;
  assign wall_tick_frequency_out = freq_q;
  assign wall_idx_out            = idx_q;
  assign collision_count_out     = cc_q;
  assign round_pass_out          = pass_q;
  assign round_fail_out          = fail_q;
  assign wall_depth_rst_out      = wrst_q;

endmodule
